// File: rtl/mem_queue_seq.sv
// Command sequencer for the buffer/LIFO/FIFO datapath: issues memory reads
// and queue PUSH/POP opcodes to load a block into the queue or drain it out.
module mem_queue_seq #(
    parameter int DinLENGTH = 32,
    parameter int ADDR_W    = 8,
    parameter int CNT_W     = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start_i,
    input  logic                 cmd_i,
    input  logic [ADDR_W-1:0]    base_addr_i,
    input  logic [CNT_W-1:0]     count_i,
    input  logic                 abort_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 err_o,
    output logic                 mem_valid_o,
    output logic                 mem_r_w_o,
    output logic [ADDR_W-1:0]    mem_addr_o,
    output logic [1:0]           q_opcode_o,
    input  logic                 q_full_i,
    input  logic                 q_empty_i,
    input  logic [DinLENGTH-1:0] q_dout_i,
    output logic [DinLENGTH-1:0] out_data_o,
    output logic                 out_valid_o
);

    typedef enum logic [2:0] {
        IDLE,
        LD_RD,
        LD_PUSH,
        DR_POP,
        DR_OUT,
        DONE
    } state_e;

    localparam logic [1:0] OP_NIMIC = 2'd0;
    localparam logic [1:0] OP_PUSH  = 2'd1;
    localparam logic [1:0] OP_POP   = 2'd2;

    state_e               state_q, state_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [CNT_W-1:0]     rem_q, rem_d;
    logic                 err_q, err_d;
    logic [DinLENGTH-1:0] out_data_q;
    logic                 out_valid_q;
    logic                 capture;
    logic                 busy;
    logic                 mem_valid;
    logic [1:0]           q_opcode;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            rem_q       <= '0;
            err_q       <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            rem_q       <= rem_d;
            err_q       <= err_d;
            out_valid_q <= capture;
            if (capture) begin
                out_data_q <= q_dout_i;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        rem_d     = rem_q;
        err_d     = 1'b0;
        capture   = 1'b0;
        busy      = 1'b0;
        mem_valid = 1'b0;
        q_opcode  = OP_NIMIC;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    addr_d = base_addr_i;
                    rem_d  = count_i;
                    if (count_i == '0) begin
                        state_d = DONE;
                    end else begin
                        state_d = cmd_i ? DR_POP : LD_RD;
                    end
                end
            end
            LD_RD: begin
                busy = 1'b1;
                if (!q_full_i) begin
                    mem_valid = 1'b1;
                    addr_d    = addr_q + ADDR_W'(1);
                    state_d   = LD_PUSH;
                end
            end
            LD_PUSH: begin
                busy     = 1'b1;
                q_opcode = OP_PUSH;
                rem_d    = rem_q - CNT_W'(1);
                state_d  = (rem_q == CNT_W'(1)) ? DONE : LD_RD;
            end
            DR_POP: begin
                busy = 1'b1;
                if (!q_empty_i) begin
                    q_opcode = OP_POP;
                    state_d  = DR_OUT;
                end
            end
            DR_OUT: begin
                busy    = 1'b1;
                capture = 1'b1;
                rem_d   = rem_q - CNT_W'(1);
                state_d = (rem_q == CNT_W'(1)) ? DONE : DR_POP;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Abort squashes whatever the busy state would have issued this cycle.
        if (busy && abort_i) begin
            state_d   = DONE;
            err_d     = 1'b1;
            addr_d    = addr_q;
            rem_d     = rem_q;
            capture   = 1'b0;
            mem_valid = 1'b0;
            q_opcode  = OP_NIMIC;
        end
    end

    assign busy_o      = busy;
    assign done_o      = (state_q == DONE);
    assign err_o       = (state_q == DONE) && err_q;
    assign mem_valid_o = mem_valid;
    assign mem_r_w_o   = 1'b0;
    assign mem_addr_o  = addr_q;
    assign q_opcode_o  = q_opcode;
    assign out_data_o  = out_data_q;
    assign out_valid_o = out_valid_q;

endmodule

// File: tb/tb_mem_queue_seq.sv
// Directed bench for mem_queue_seq with a 4-deep queue and 1-cycle memory.
module tb_mem_queue_seq;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        cmd = 1'b0;
    logic [7:0]  base_addr = '0;
    logic [7:0]  count = '0;
    logic        abort = 1'b0;
    logic        busy, done, err, mem_valid, mem_r_w;
    logic [7:0]  mem_addr;
    logic [1:0]  q_opcode;
    logic        q_full = 1'b0;
    logic        q_empty = 1'b1;
    logic [31:0] q_dout = '0;
    logic [31:0] out_data;
    logic        out_valid;

    logic        ext_push = 1'b0;
    logic        ext_pop = 1'b0;
    logic [31:0] ext_data = '0;
    logic [31:0] mem_rdata = '0;
    logic [31:0] qq[$];

    int checks = 0;
    int errors = 0;

    mem_queue_seq dut (
        .clk         (clk),
        .reset       (reset),
        .start_i     (start),
        .cmd_i       (cmd),
        .base_addr_i (base_addr),
        .count_i     (count),
        .abort_i     (abort),
        .busy_o      (busy),
        .done_o      (done),
        .err_o       (err),
        .mem_valid_o (mem_valid),
        .mem_r_w_o   (mem_r_w),
        .mem_addr_o  (mem_addr),
        .q_opcode_o  (q_opcode),
        .q_full_i    (q_full),
        .q_empty_i   (q_empty),
        .q_dout_i    (q_dout),
        .out_data_o  (out_data),
        .out_valid_o (out_valid)
    );

    always #5 clk = ~clk;

    // Memory: word at address a reads back as C0FFEE_aa one cycle later.
    always @(posedge clk) begin
        if (mem_valid) mem_rdata <= {24'hC0FFEE, mem_addr};
    end

    // Queue: FIFO, depth 4, registered flags and pop data.
    always @(posedge clk) begin
        if ((ext_push || q_opcode == 2'd1) && qq.size() < 4)
            qq.push_back(ext_push ? ext_data : mem_rdata);
        if ((ext_pop || q_opcode == 2'd2) && qq.size() > 0)
            q_dout <= qq.pop_front();
        q_full  <= (qq.size() >= 4);
        q_empty <= (qq.size() == 0);
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic go(input logic c, input logic [7:0] a, input logic [7:0] n);
        cmd = c;
        base_addr = a;
        count = n;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic all_zero(input string tag);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_done"}, {31'd0, done}, 32'd0);
        chk({tag, "_err"}, {31'd0, err}, 32'd0);
        chk({tag, "_mvalid"}, {31'd0, mem_valid}, 32'd0);
        chk({tag, "_rw"}, {31'd0, mem_r_w}, 32'd0);
        chk({tag, "_addr"}, {24'd0, mem_addr}, 32'd0);
        chk({tag, "_op"}, {30'd0, q_opcode}, 32'd0);
        chk({tag, "_ovalid"}, {31'd0, out_valid}, 32'd0);
        chk({tag, "_odata"}, out_data, 32'd0);
    endtask

    initial begin
        #2 reset = 1'b1;
        #2 all_zero("reset");
        @(negedge clk) reset = 1'b0;
        tick();

        // count = 0: immediate done, nothing issued
        go(1'b0, 8'h40, 8'd0);
        chk("cnt0_done", {31'd0, done}, 32'd1);
        chk("cnt0_err", {31'd0, err}, 32'd0);
        chk("cnt0_mvalid", {31'd0, mem_valid}, 32'd0);
        chk("cnt0_op", {30'd0, q_opcode}, 32'd0);
        tick();

        // LOAD 3 words from 0x10
        go(1'b0, 8'h10, 8'd3);
        chk("ld3_c1_mv", {31'd0, mem_valid}, 32'd1);
        chk("ld3_c1_addr", {24'd0, mem_addr}, 32'h10);
        chk("ld3_c1_busy", {31'd0, busy}, 32'd1);
        tick();
        chk("ld3_c2_op", {30'd0, q_opcode}, 32'd1);
        chk("ld3_c2_mv", {31'd0, mem_valid}, 32'd0);
        tick();
        chk("ld3_c3_addr", {23'd0, mem_valid, mem_addr}, 32'h111);
        tick();
        chk("ld3_c4_op", {30'd0, q_opcode}, 32'd1);
        tick();
        chk("ld3_c5_addr", {23'd0, mem_valid, mem_addr}, 32'h112);
        tick();
        chk("ld3_c6_op", {30'd0, q_opcode}, 32'd1);
        tick();
        chk("ld3_c7_done", {30'd0, done, err}, 32'b10);
        chk("ld3_c7_busy", {31'd0, busy}, 32'd0);
        tick();
        chk("ld3_c8_done", {31'd0, done}, 32'd0);

        // DRAIN those 3 words in order
        go(1'b1, 8'h00, 8'd3);
        chk("dr3_c1_op", {30'd0, q_opcode}, 32'd2);
        tick();
        chk("dr3_c2_op", {30'd0, q_opcode}, 32'd0);
        tick();
        chk("dr3_c3_ov", {31'd0, out_valid}, 32'd1);
        chk("dr3_c3_data", out_data, 32'hC0FFEE10);
        tick();
        chk("dr3_c4_ov", {31'd0, out_valid}, 32'd0);
        tick();
        chk("dr3_c5_data", out_data, 32'hC0FFEE11);
        ticks(2);
        chk("dr3_c7_done", {30'd0, done, err}, 32'b10);
        chk("dr3_c7_data", {31'd0, out_valid}, 32'd1);
        chk("dr3_c7_word", out_data, 32'hC0FFEE12);
        tick();

        // LOAD with address wrap
        go(1'b0, 8'hFE, 8'd3);
        chk("wrap_a0", {23'd0, mem_valid, mem_addr}, 32'h1FE);
        ticks(2);
        chk("wrap_a1", {23'd0, mem_valid, mem_addr}, 32'h1FF);
        ticks(2);
        chk("wrap_a2", {23'd0, mem_valid, mem_addr}, 32'h100);
        ticks(2);
        chk("wrap_done", {31'd0, done}, 32'd1);
        tick();
        go(1'b1, 8'h00, 8'd3);
        ticks(6);
        chk("wrap_dr_done", {31'd0, done}, 32'd1);
        chk("wrap_dr_word", out_data, 32'hC0FFEE00);
        tick();

        // LOAD 6 into a 4-deep queue: stall on full, resume after pops
        go(1'b0, 8'h20, 8'd6);
        ticks(8);
        chk("full_c9_mv", {31'd0, mem_valid}, 32'd0);
        chk("full_c9_busy", {31'd0, busy}, 32'd1);
        tick();
        chk("full_c10_mv", {31'd0, mem_valid}, 32'd0);
        chk("full_c10_op", {30'd0, q_opcode}, 32'd0);
        tick();
        ext_pop = 1'b1;
        chk("full_c11_mv", {31'd0, mem_valid}, 32'd0);
        tick();
        chk("full_c12_rd", {23'd0, mem_valid, mem_addr}, 32'h124);
        tick();
        ext_pop = 1'b0;
        chk("full_c13_op", {30'd0, q_opcode}, 32'd1);
        tick();
        chk("full_c14_rd", {23'd0, mem_valid, mem_addr}, 32'h125);
        ticks(2);
        chk("full_c16_done", {30'd0, done, err}, 32'b10);
        tick();
        go(1'b1, 8'h00, 8'd4);
        ticks(2);
        chk("full_dr_first", out_data, 32'hC0FFEE22);
        ticks(6);
        chk("full_dr_done", {31'd0, done}, 32'd1);
        chk("full_dr_last", out_data, 32'hC0FFEE25);
        tick();

        // DRAIN of externally pushed patterns
        ext_push = 1'b1;
        ext_data = 32'hA5A5A5A5;
        tick();
        ext_data = 32'h5A5A5A5A;
        tick();
        ext_push = 1'b0;
        tick();
        go(1'b1, 8'h00, 8'd2);
        chk("pat_c1_op", {30'd0, q_opcode}, 32'd2);
        ticks(2);
        chk("pat_c3_ov", {31'd0, out_valid}, 32'd1);
        chk("pat_c3_data", out_data, 32'hA5A5A5A5);
        ticks(2);
        chk("pat_c5_ov", {31'd0, out_valid}, 32'd1);
        chk("pat_c5_data", out_data, 32'h5A5A5A5A);
        chk("pat_c5_done", {31'd0, done}, 32'd1);
        tick();

        // DRAIN on empty queue stalls, then abort
        go(1'b1, 8'h00, 8'd2);
        for (int i = 1; i <= 5; i++) begin
            chk("empty_op", {30'd0, q_opcode}, 32'd0);
            chk("empty_busy", {31'd0, busy}, 32'd1);
            chk("empty_done", {31'd0, done}, 32'd0);
            if (i < 5) tick();
        end
        abort = 1'b1;
        #1 chk("abort_op", {30'd0, q_opcode}, 32'd0);
        tick();
        abort = 1'b0;
        chk("abort_done_err", {30'd0, done, err}, 32'b11);
        tick();
        chk("abort_after", {30'd0, done, err}, 32'b00);

        // Reset during LD_PUSH: outputs clear at once, no done pulse
        go(1'b0, 8'h30, 8'd2);
        tick();
        chk("rst_push_op", {30'd0, q_opcode}, 32'd1);
        reset = 1'b1;
        #1 all_zero("midrst");
        @(negedge clk) reset = 1'b0;
        tick();
        chk("midrst_c1_done", {30'd0, done, busy}, 32'd0);
        tick();
        chk("midrst_c2_done", {30'd0, done, busy}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_queue_seq.md
# mem_queue_seq

Command sequencer that initiates the memory and queue transactions of the buffer/LIFO/FIFO datapath. It sits upstream of the addressed memory and the queue. On a single start command it either loads a block of words from memory into the queue (LOAD) or drains words from the queue to a streaming output (DRAIN). It generates valid/r_w/addr toward the memory and PUSH/POP opcodes toward the queue, and obeys the queue's full/empty flags.

## Interface
- DinLENGTH, 32, data word width
- ADDR_W, 8, memory address width
- CNT_W, 8, transfer count width

- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- start  in  1  command strobe; sampled only in IDLE
- cmd  in  1  0 = LOAD (memory→queue), 1 = DRAIN (queue→out)
- base_addr  in  ADDR_W  first memory address for LOAD
- count  in  CNT_W  number of words to transfer
- abort  in  1  terminate the current command
- busy  out  1  command in progress
- done  out  1  one-cycle completion pulse
- err  out  1  valid with done; 1 = command was aborted
- mem_valid  out  1  memory access strobe
- mem_r_w  out  1  1 = write, 0 = read; this block always drives 0
- mem_addr  out  ADDR_W  memory address
- q_opcode  out  2  0 NIMIC, 1 PUSH, 2 POP, 3 PUSH_POP (never driven)
- q_full  in  1  queue full flag (registered by queue)
- q_empty  in  1  queue empty flag (registered by queue)
- q_dout  in  DinLENGTH  queue pop data (registered by queue)
- out_data  out  DinLENGTH  drained word
- out_valid  out  1  out_data valid, one-cycle pulse per word

## Operation
- States: IDLE, LD_RD, LD_PUSH, DR_POP, DR_OUT, DONE.
- On reset, state is IDLE. All outputs are 0, including out_data. The address and remaining-count registers are cleared.
- IDLE:
  - When start=1, latch base_addr into the address register and count into the remaining-count register (rem).
  - If count=0 → DONE with err=0, and no transactions are issued.
  - Otherwise cmd=0 → LD_RD, and cmd=1 → DR_POP.
  - start outside IDLE is ignored.
- LD_RD:
  - If q_full=1, stall: mem_valid=0 and the state holds.
  - Otherwise drive mem_valid=1, mem_r_w=0, mem_addr=address register. Increment the address modulo 2^ADDR_W and go to LD_PUSH.
- LD_PUSH:
  - q_opcode=PUSH for one cycle; the memory read data is at the queue input this cycle.
  - Decrement rem. If rem was 1 → DONE, else → LD_RD.
- DR_POP:
  - If q_empty=1, stall with q_opcode=NIMIC.
  - Otherwise q_opcode=POP for one cycle, then → DR_OUT.
- DR_OUT:
  - Register q_dout into out_data and set out_valid=1 for the next cycle.
  - Decrement rem. If rem was 1 → DONE, else → DR_POP.
- DONE: done=1 for one cycle, busy=0, then → IDLE.
- busy=1 in LD_RD, LD_PUSH, DR_POP and DR_OUT only.
- abort=1 in any busy state → DONE at the next edge with err=1. q_opcode and mem_valid are 0 in the abort cycle, so no partial transaction is issued. abort in IDLE or DONE is ignored.
- err is 0 whenever done is 0.
- The full/empty flags are trusted only in LD_RD and DR_POP. Because each push/pop is followed by a non-issuing state, the flag updates are always visible before the next issue.

## Timing
- Memory read latency is 1 cycle, and the queue samples the opcode at the edge ending the cycle.
- Throughput: 2 cycles per word with no stalls.
- A LOAD of N words issued in cycle 0 finishes in DONE at cycle 2N+1.
- A DRAIN word popped in cycle k appears on out_data with out_valid=1 in cycle k+2.
- A stall adds exactly one cycle per cycle that q_full or q_empty is held.
- Reset mid-command returns to IDLE immediately with all outputs 0, and done is not pulsed.

## Test plan
- LOAD of 3 words from base_addr=0x10, queue empty:
  - Reads at 0x10, 0x11 and 0x12 in cycles 1, 3 and 5.
  - PUSH in cycles 2, 4 and 6.
  - done=1 with err=0 in cycle 7.
- LOAD with base_addr=0xFE and count=3 → addresses 0xFE, 0xFF, 0x00 (wrap-around).
- LOAD of 6 words into a 4-deep queue, with no pop in between:
  - 4 pushes, then the block holds LD_RD with mem_valid=0 while q_full=1.
  - After 2 external POPs, it resumes and completes.
- DRAIN of 2 words after pushing 0xA5A5A5A5 and 0x5A5A5A5A → out_valid pulses carry those values in queue order, then done=1.
- DRAIN with the queue empty for 5 cycles → q_opcode stays 0 and busy=1 throughout. Then assert abort → done=1, err=1 at the next cycle.
- count=0 → done pulse at cycle 1 with no mem_valid and no opcode. Assert reset during LD_PUSH → all outputs 0 immediately, and no done pulse.
